popcount_accumulator: RTL and testbench

Downstream consumer of the 4-input ones-counter stage. It takes the 3-bit ones count (0..4) over a valid/ready handshake and sums WINDOW consecutive accepted samples. It then presents the window total on a held valid/ready output. Saturation and illegal-input status are reported per window.

---
 rtl/popcount_accumulator.sv | 111 +++++++++++
 tb/tb_popcount_accumulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_accumulator.sv
// Sums WINDOW accepted ones-counts (0..4) into a saturating total and presents
// it on a held valid/ready output together with per-window saturation/illegal-input flags.
module popcount_accumulator #(
    parameter int WINDOW = 16,
    parameter int SUM_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [2:0]       cnt_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SUM_W-1:0] sum_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sat,
    output logic             bad
);

    localparam int               EXT_W    = ((SUM_W > 3) ? SUM_W : 3) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX  = '1;
    localparam logic [7:0]       LAST_IDX = 8'(WINDOW - 1);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]       state;
    logic [SUM_W-1:0] acc;
    logic [7:0]       idx;
    logic             sat_r;
    logic             bad_r;

    logic [2:0]       samp;
    logic [SUM_W:0]   add_res;
    logic [SUM_W-1:0] acc_nxt;
    logic             sat_nxt;
    logic             bad_nxt;

    // Illegal counts 5..7 contribute as the largest legal value.
    function automatic logic [2:0] clamp_cnt(input logic [2:0] c);
        return (c > 3'd4) ? 3'd4 : c;
    endfunction

    // Returns {overflow, clamped sum}.
    function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] a, input logic [2:0] b);
        logic [EXT_W-1:0] s;
        s = EXT_W'(a) + EXT_W'(b);
        if (s > EXT_W'(SUM_MAX))
            return {1'b1, SUM_MAX};
        else
            return {1'b0, s[SUM_W-1:0]};
    endfunction

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);

    always_comb begin
        samp    = clamp_cnt(cnt_in);
        add_res = sat_add(acc, samp);
        acc_nxt = add_res[SUM_W-1:0];
        sat_nxt = sat_r | add_res[SUM_W];
        bad_nxt = bad_r | (cnt_in > 3'd4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            acc     <= '0;
            idx     <= '0;
            sat_r   <= 1'b0;
            bad_r   <= 1'b0;
            sum_out <= '0;
            sat     <= 1'b0;
            bad     <= 1'b0;
        end else if (clr) begin
            state <= ACCUM;
            acc   <= '0;
            idx   <= '0;
            sat_r <= 1'b0;
            bad_r <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (idx == LAST_IDX) begin
                            sum_out <= acc_nxt;
                            sat     <= sat_nxt;
                            bad     <= bad_nxt;
                            state   <= HOLD;
                            acc     <= '0;
                            idx     <= '0;
                            sat_r   <= 1'b0;
                            bad_r   <= 1'b0;
                        end else begin
                            acc   <= acc_nxt;
                            idx   <= idx + 8'd1;
                            sat_r <= sat_nxt;
                            bad_r <= bad_nxt;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready)
                        state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_accumulator.sv
// Bench for popcount_accumulator: three instances (16/8, 4/8, 16/5) driven by
// directed and randomized windows, checked against a window-level arithmetic model.
module tb_popcount_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] cnt [3];
    logic [2:0] iv, ordy, clr;
    logic [2:0] ir, ov, sa, bd;
    logic [7:0] so0, so1;
    logic [4:0] so2;

    int checks = 0;
    int errors = 0;
    int win  [3] = '{16, 4, 16};
    int maxv [3] = '{255, 255, 31};

    always #5 clk = ~clk;

    popcount_accumulator #(.WINDOW(16), .SUM_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]), .cnt_in(cnt[0]), .in_valid(iv[0]),
        .in_ready(ir[0]), .sum_out(so0), .out_valid(ov[0]), .out_ready(ordy[0]),
        .sat(sa[0]), .bad(bd[0]));
    popcount_accumulator #(.WINDOW(4), .SUM_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]), .cnt_in(cnt[1]), .in_valid(iv[1]),
        .in_ready(ir[1]), .sum_out(so1), .out_valid(ov[1]), .out_ready(ordy[1]),
        .sat(sa[1]), .bad(bd[1]));
    popcount_accumulator #(.WINDOW(16), .SUM_W(5)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr[2]), .cnt_in(cnt[2]), .in_valid(iv[2]),
        .in_ready(ir[2]), .sum_out(so2), .out_valid(ov[2]), .out_ready(ordy[2]),
        .sat(sa[2]), .bad(bd[2]));

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

    function automatic int sumv(int d);
        case (d)
            0: return int'(so0);
            1: return int'(so1);
            default: return int'(so2);
        endcase
    endfunction

    // Window-level reference: total of clamped samples, limited to the output range.
    function automatic int model_total(int q[$]);
        int s = 0;
        foreach (q[i]) s += (q[i] > 4) ? 4 : q[i];
        return s;
    endfunction

    function automatic int model_sum(int q[$], int mx);
        int s = model_total(q);
        return (s > mx) ? mx : s;
    endfunction

    function automatic logic model_bad(int q[$]);
        foreach (q[i]) if (q[i] > 4) return 1'b1;
        return 1'b0;
    endfunction

    task automatic send(int d, int x);
        @(negedge clk);
        cnt[d] = 3'(x);
        iv[d]  = 1'b1;
    endtask

    task automatic idle(int d, int n);
        repeat (n) begin
            @(negedge clk);
            iv[d] = 1'b0;
        end
    endtask

    task automatic handshake(int d);
        @(negedge clk);
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++; if (ov[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got %b want 0", d, ov[d]); end
            checks++; if (ir[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got %b want 1", d, ir[d]); end
            checks++; if (sumv(d) !== 0) begin errors++; $display("FAIL reset_sum[%0d] got %0d want 0", d, sumv(d)); end
            checks++; if ({sa[d], bd[d]} !== 2'b00) begin errors++; $display("FAIL reset_flags[%0d] got %b want 00", d, {sa[d], bd[d]}); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_window();
        for (int i = 0; i < 16; i++) begin
            send(0, 4);
            if (i == 15) begin
                checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL full_early_valid got %b want 0", ov[0]); end
            end
        end
        idle(0, 1);
        checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL full_valid got %b want 1", ov[0]); end
        checks++; if (sumv(0) !== 64) begin errors++; $display("FAIL full_sum got %0d want 64", sumv(0)); end
        checks++; if ({sa[0], bd[0]} !== 2'b00) begin errors++; $display("FAIL full_flags got %b want 00", {sa[0], bd[0]}); end
        idle(0, 2);
        checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL full_in_ready_hold got %b want 0", ir[0]); end
        handshake(0);
        checks++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin errors++; $display("FAIL full_release got ov=%b ir=%b want ov=0 ir=1", ov[0], ir[0]); end
    endtask

    task automatic test_mixed_gaps();
        int q[$] = '{1, 0, 3, 2};
        foreach (q[i]) begin
            send(1, q[i]);
            if (i < 3) idle(1, 2);
        end
        idle(1, 1);
        checks++; if (ov[1] !== 1'b1) begin errors++; $display("FAIL gaps_valid got %b want 1", ov[1]); end
        checks++; if (sumv(1) !== model_sum(q, 255)) begin errors++; $display("FAIL gaps_sum got %0d want %0d", sumv(1), model_sum(q, 255)); end
        handshake(1);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) send(1, 3);
        idle(1, 1);
        checks++; if (sumv(1) !== 12) begin errors++; $display("FAIL bp_sum got %0d want 12", sumv(1)); end
        for (int c = 0; c < 5; c++) begin
            send(1, 2);
            checks++; if (ov[1] !== 1'b1 || ir[1] !== 1'b0 || sumv(1) !== 12) begin
                errors++; $display("FAIL bp_hold got ov=%b ir=%b sum=%0d want ov=1 ir=0 sum=12", ov[1], ir[1], sumv(1));
            end
        end
        @(negedge clk);
        ordy[1] = 1'b1;
        @(negedge clk);
        ordy[1] = 1'b0;
        checks++; if (ov[1] !== 1'b0 || ir[1] !== 1'b1) begin errors++; $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", ov[1], ir[1]); end
        repeat (3) @(negedge clk);
        checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL bp_next_early got %b want 0", ov[1]); end
        idle(1, 1);
        checks++; if (ov[1] !== 1'b1 || sumv(1) !== 8) begin errors++; $display("FAIL bp_next_window got ov=%b sum=%0d want ov=1 sum=8", ov[1], sumv(1)); end
        handshake(1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 16; i++) send(2, 7);
        idle(2, 1);
        checks++; if (sumv(2) !== 31 || sa[2] !== 1'b1 || bd[2] !== 1'b1) begin
            errors++; $display("FAIL sat_window got sum=%0d sat=%b bad=%b want 31 1 1", sumv(2), sa[2], bd[2]);
        end
        handshake(2);
        for (int i = 0; i < 16; i++) send(2, 1);
        idle(2, 1);
        checks++; if (sumv(2) !== 16 || sa[2] !== 1'b0 || bd[2] !== 1'b0) begin
            errors++; $display("FAIL sat_next_window got sum=%0d sat=%b bad=%b want 16 0 0", sumv(2), sa[2], bd[2]);
        end
        handshake(2);
    endtask

    task automatic test_clr();
        send(1, 2);
        send(1, 2);
        @(negedge clk);
        clr[1] = 1'b1; cnt[1] = 3'd4; iv[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        iv[1] = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 1);
        idle(1, 1);
        checks++; if (ov[1] !== 1'b1 || sumv(1) !== 4) begin errors++; $display("FAIL clr_mid got ov=%b sum=%0d want ov=1 sum=4", ov[1], sumv(1)); end
        @(negedge clk);
        clr[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        checks++; if (ov[1] !== 1'b0 || ir[1] !== 1'b1) begin errors++; $display("FAIL clr_hold got ov=%b ir=%b want ov=0 ir=1", ov[1], ir[1]); end
    endtask

    task automatic test_async_reset();
        int q[$];
        send(1, 3);
        send(1, 3);
        idle(1, 1);
        for (int i = 0; i < 16; i++) send(2, 7);
        idle(2, 1);
        checks++; if (ov[2] !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b want 1", ov[2]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ov[2] !== 1'b0 || sumv(2) !== 0 || sa[2] !== 1'b0 || bd[2] !== 1'b0) begin
            errors++; $display("FAIL arst_clear got ov=%b sum=%0d sat=%b bad=%b want 0 0 0 0", ov[2], sumv(2), sa[2], bd[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(1, 1);
        idle(1, 1);
        checks++; if (ov[1] !== 1'b1 || sumv(1) !== 4) begin errors++; $display("FAIL arst_partial_lost got ov=%b sum=%0d want ov=1 sum=4", ov[1], sumv(1)); end
        handshake(1);
        for (int i = 0; i < 16; i++) q.push_back(int'($urandom_range(0, 4)));
        foreach (q[i]) send(2, q[i]);
        idle(2, 1);
        checks++; if (sumv(2) !== model_sum(q, 31) || ov[2] !== 1'b1) begin
            errors++; $display("FAIL arst_fresh got ov=%b sum=%0d want ov=1 sum=%0d", ov[2], sumv(2), model_sum(q, 31));
        end
        handshake(2);
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            int d = k % 3;
            int q[$];
            logic es, eb;
            int ex;
            for (int i = 0; i < win[d]; i++)
                q.push_back(($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4)));
            foreach (q[i]) begin
                send(d, q[i]);
                idle(d, int'($urandom_range(0, 2)));
            end
            idle(d, 1);
            ex = model_sum(q, maxv[d]);
            es = (model_total(q) > maxv[d]);
            eb = model_bad(q);
            checks++; if (ov[d] !== 1'b1 || sumv(d) !== ex || sa[d] !== es || bd[d] !== eb) begin
                errors++; $display("FAIL rand[%0d] d=%0d got ov=%b sum=%0d sat=%b bad=%b want ov=1 sum=%0d sat=%b bad=%b",
                                   k, d, ov[d], sumv(d), sa[d], bd[d], ex, es, eb);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake(d);
            checks++; if (ov[d] !== 1'b0) begin errors++; $display("FAIL rand_release[%0d] got %b want 0", k, ov[d]); end
        end
    endtask

    initial begin
        iv = '0; ordy = '0; clr = '0;
        for (int d = 0; d < 3; d++) cnt[d] = 3'd0;
        test_reset();
        test_full_window();
        test_mixed_gaps();
        test_backpressure();
        test_saturation();
        test_clr();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
